// File: rtl/edge_pe_task_port_pkg.sv
// edge_pe_task_port_pkg
// Shared definitions for the Edge-PE task port: field widths, request type
// codes, the endpoint FSM state enum and packed views of the task and request
// packets. Everything that sizes the task/request packets lives here so the
// interface and the endpoint always agree.
package edge_pe_task_port_pkg;

   localparam int PACKET_W = 16;           // request packet width
   localparam int ADDR_W   = 10;           // edge base address field width
   localparam int CNT_W    = 4;            // edge count / edge index width
   localparam int TASK_W   = PACKET_W - 2; // task packet width (ADDR_W+CNT_W)

   localparam logic [1:0] REQ      = 2'b01;
   localparam logic [1:0] LAST_REQ = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_COMPUTE = 2'd2
   } state_t;

   // Task packet as delivered by the reservation station.
   typedef struct packed {
      logic [CNT_W-1:0]  edge_count;   // 0 encodes 16 edges
      logic [ADDR_W-1:0] base_addr;
   } task_pkt_t;

   // Request packet sent toward the IMEM packet controller.
   typedef struct packed {
      logic [1:0]        req_type;
      logic [CNT_W-1:0]  edge_idx;
      logic [ADDR_W-1:0] addr;
   } req_pkt_t;

   // Builds the request for edge idx; the address wraps inside ADDR_W bits.
   function automatic req_pkt_t make_req(input logic [CNT_W-1:0]  idx,
                                         input logic [CNT_W-1:0]  last_idx,
                                         input logic [ADDR_W-1:0] base);
      req_pkt_t r;
      r.req_type = (idx == last_idx) ? LAST_REQ : REQ;
      r.edge_idx = idx;
      r.addr     = base + ADDR_W'(idx);
      return r;
   endfunction

endpackage

// File: rtl/edge_pe_task_port_if.sv
// edge_pe_task_port_if
// Bundles the task dispatch channel and the IMEM request channel seen by one
// Edge PE.
//   task_in_packet / task_in_valid : task from the reservation station
//   pe_idle                        : PE can take a new task
//   req_out_packet / req_out_valid : per-edge request strobe toward IMEM
//   bank_busy                      : target IMEM bank cannot accept a request
// Modports: master = dispatcher/IMEM side, slave = Edge-PE endpoint.
interface edge_pe_task_port_if;
   import edge_pe_task_port_pkg::*;

   logic [TASK_W-1:0]   task_in_packet;
   logic                task_in_valid;
   logic                pe_idle;
   logic [PACKET_W-1:0] req_out_packet;
   logic                req_out_valid;
   logic                bank_busy;

   modport master (
      output task_in_packet, task_in_valid, bank_busy,
      input  pe_idle, req_out_packet, req_out_valid
   );

   modport slave (
      input  task_in_packet, task_in_valid, bank_busy,
      output pe_idle, req_out_packet, req_out_valid
   );

endinterface

// File: rtl/edge_pe_task_port.sv
// edge_pe_task_port
// Edge-PE endpoint of the task dispatch / IMEM request interface. Takes one
// task (edge_count, base_addr), walks its edge list issuing one request per
// edge when the IMEM bank is free, and spends PROC_CYCLES cycles (strobe cycle
// included) computing on each edge before the next request.
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high
//   abort      : flush the current task, return to idle
//   port       : task/request channel bundle (slave side)
//   tasks_done : completed-task counter, wraps 255 -> 0
//   overflow   : sticky, a task arrived while the PE was busy
// All outputs are registered. PROC_CYCLES legal range is 1..15.
module edge_pe_task_port
   import edge_pe_task_port_pkg::*;
#(
   parameter int PROC_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               abort,
   edge_pe_task_port_if.slave port,
   output logic [7:0]         tasks_done,
   output logic               overflow
);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] COMP_LOAD = CNT_W'(PROC_CYCLES - 1);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  idx_reg, idx_next;
   logic [CNT_W-1:0]  last_idx_reg, last_idx_next;
   logic [CNT_W-1:0]  comp_cnt_reg, comp_cnt_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   req_pkt_t          req_pkt_reg, req_pkt_next;
   logic              req_valid_reg, req_valid_next;
   logic              pe_idle_reg, pe_idle_next;
   logic              overflow_reg, overflow_next;
   logic [7:0]        tasks_done_reg, tasks_done_next;

   task_pkt_t task_pkt;
   logic      last_edge;
   logic      comp_done;

   assign task_pkt  = port.task_in_packet;
   assign last_edge = (idx_reg == last_idx_reg);
   assign comp_done = (comp_cnt_reg == '0);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         idx_reg        <= '0;
         last_idx_reg   <= '0;
         comp_cnt_reg   <= '0;
         base_reg       <= '0;
         req_pkt_reg    <= '0;
         req_valid_reg  <= 1'b0;
         pe_idle_reg    <= 1'b1;
         overflow_reg   <= 1'b0;
         tasks_done_reg <= '0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         last_idx_reg   <= last_idx_next;
         comp_cnt_reg   <= comp_cnt_next;
         base_reg       <= base_next;
         req_pkt_reg    <= req_pkt_next;
         req_valid_reg  <= req_valid_next;
         pe_idle_reg    <= pe_idle_next;
         overflow_reg   <= overflow_next;
         tasks_done_reg <= tasks_done_next;
      end
   end

   // Next-state logic; abort overrides everything
   always_comb begin
      state_next = state_reg;
      if (abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:    if (port.task_in_valid) state_next = ST_ISSUE;
            ST_ISSUE:   if (!port.bank_busy)    state_next = ST_COMPUTE;
            ST_COMPUTE: if (comp_done)          state_next = last_edge ? ST_IDLE : ST_ISSUE;
            default:                            state_next = ST_IDLE;
         endcase
      end
   end

   // Output / datapath next values
   always_comb begin
      idx_next        = idx_reg;
      last_idx_next   = last_idx_reg;
      comp_cnt_next   = comp_cnt_reg;
      base_next       = base_reg;
      req_pkt_next    = req_pkt_reg;     // packet holds between strobes
      req_valid_next  = 1'b0;
      pe_idle_next    = (state_next == ST_IDLE);
      overflow_next   = overflow_reg;
      tasks_done_next = tasks_done_reg;

      if (!abort) begin
         // A task offered while working is dropped and only flagged.
         if (port.task_in_valid && state_reg != ST_IDLE)
            overflow_next = 1'b1;

         case (state_reg)
            ST_IDLE: begin
               if (port.task_in_valid) begin
                  base_next     = task_pkt.base_addr;
                  // edge_count 0 means 16 edges: 0 - 1 wraps to 15.
                  last_idx_next = task_pkt.edge_count - CNT_ONE;
                  idx_next      = '0;
               end
            end
            ST_ISSUE: begin
               if (!port.bank_busy) begin
                  req_valid_next = 1'b1;
                  req_pkt_next   = make_req(idx_reg, last_idx_reg, base_reg);
                  comp_cnt_next  = COMP_LOAD;
               end
            end
            ST_COMPUTE: begin
               if (!comp_done)
                  comp_cnt_next = comp_cnt_reg - CNT_ONE;
               else if (!last_edge)
                  idx_next = idx_reg + CNT_ONE;
               else
                  tasks_done_next = tasks_done_reg + 8'd1;
            end
            default: ;
         endcase
      end
   end

   assign port.req_out_packet = req_pkt_reg;
   assign port.req_out_valid  = req_valid_reg;
   assign port.pe_idle        = pe_idle_reg;
   assign tasks_done          = tasks_done_reg;
   assign overflow            = overflow_reg;

endmodule

// File: tb/tb_edge_pe_task_port.sv
// tb_edge_pe_task_port
// Builds a whole stimulus program (directed scenarios, a random section and a
// 256-task counter-wrap run) into per-cycle arrays, derives the expected
// per-cycle outputs from a task-level schedule, then plays the program into
// the endpoint and compares every cycle plus a set of fixed-value checks.
module tb_edge_pe_task_port;
   import edge_pe_task_port_pkg::*;

   localparam int P      = 2;
   localparam int RAND0  = 80;
   localparam int RANDN  = 3000;
   localparam int W0     = RAND0 + RANDN + 60;    // reset before wrap run
   localparam int WSPAN  = 49;                     // 16 edges * (P+1) + 1
   localparam int NCYC   = W0 + 1 + WSPAN * 256 + 20;
   localparam int NBUF   = 16000;

   logic       clk = 1'b0;
   logic       reset;
   logic       abort;
   logic [7:0] tasks_done;
   logic       overflow;

   edge_pe_task_port_if bus ();

   edge_pe_task_port #(.PROC_CYCLES(P)) dut (
      .clk        (clk),
      .reset      (reset),
      .abort      (abort),
      .port       (bus),
      .tasks_done (tasks_done),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // stimulus program, index = clock edge
   bit          tv_a   [NBUF];
   logic [13:0] tp_a   [NBUF];
   bit          busy_a [NBUF];
   bit          ab_a   [NBUF];
   bit          rst_a  [NBUF];

   // schedule events and expected outputs after each edge
   bit          strobe_a [NBUF];
   logic [15:0] spkt_a   [NBUF];
   bit          busy_lo  [NBUF];
   bit          done_inc [NBUF];
   bit          ovf_set  [NBUF];
   bit          exp_v    [NBUF];
   logic [15:0] exp_pkt  [NBUF];
   bit          exp_idle [NBUF];
   logic [7:0]  exp_done [NBUF];
   bit          exp_ovf  [NBUF];

   // observed outputs after each edge
   logic        obs_v    [NBUF];
   logic [15:0] obs_pkt  [NBUF];
   logic        obs_idle [NBUF];
   logic [7:0]  obs_done [NBUF];
   logic        obs_ovf  [NBUF];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic put_task(input int c, input logic [3:0] cnt, input logic [9:0] base);
      tv_a[c] = 1'b1;
      tp_a[c] = {cnt, base};
   endtask

   // Task-level reference: when a task is accepted, lay out its request edges
   // from the known bank_busy pattern, then cut it at the first abort/reset.
   task automatic build_expect();
      int c, t, n, e, fin, stop;
      bit intr;
      int st_edge [16];
      logic [9:0]  base, addr;
      logic [3:0]  cnt, kk;
      logic [15:0] pkt;
      logic [7:0]  done;
      bit idle_bit, ovf;
      for (int i = 0; i < NBUF; i++) begin
         strobe_a[i] = 0; spkt_a[i] = '0; busy_lo[i] = 0; done_inc[i] = 0; ovf_set[i] = 0;
      end
      c = 0;
      while (c < NCYC) begin
         if (rst_a[c] || ab_a[c] || !tv_a[c]) begin
            c++;
            continue;
         end
         t    = c;
         cnt  = tp_a[c][13:10];
         base = tp_a[c][9:0];
         n    = (cnt == 4'd0) ? 16 : int'(cnt);
         e    = t + 1;
         fin  = t;
         for (int k = 0; k < n; k++) begin
            while (e < NCYC && busy_a[e]) e++;
            st_edge[k] = e;
            fin = e + P;
            e   = fin + 1;
         end
         stop = fin;
         intr = 0;
         for (int x = t + 1; x <= fin && x < NBUF; x++) begin
            if (rst_a[x] || ab_a[x]) begin
               stop = x;
               intr = 1;
               break;
            end
         end
         for (int k = 0; k < n; k++) begin
            if (st_edge[k] < stop) begin
               kk   = 4'(k);
               addr = base + 10'(k);
               strobe_a[st_edge[k]] = 1;
               spkt_a[st_edge[k]]   = {(k == n - 1) ? 2'b10 : 2'b01, kk, addr};
            end
         end
         for (int x = t; x < stop; x++) busy_lo[x] = 1;
         if (!intr) done_inc[stop] = 1;
         for (int x = t + 1; x <= stop; x++)
            if (tv_a[x] && !(intr && x == stop)) ovf_set[x] = 1;
         c = stop + 1;
      end
      pkt = '0; done = '0; ovf = 0;
      for (int i = 0; i < NCYC; i++) begin
         if (rst_a[i]) begin
            pkt = '0; done = '0; ovf = 0; idle_bit = 1;
            exp_v[i] = 0;
         end else begin
            exp_v[i] = strobe_a[i];
            if (strobe_a[i]) pkt = spkt_a[i];
            idle_bit = !busy_lo[i];
            if (done_inc[i]) done = done + 8'd1;
            if (ovf_set[i]) ovf = 1;
         end
         exp_pkt[i]  = pkt;
         exp_idle[i] = idle_bit;
         exp_done[i] = done;
         exp_ovf[i]  = ovf;
      end
   endtask

   initial begin
      int tw;
      for (int i = 0; i < NBUF; i++) begin
         tv_a[i] = 0; tp_a[i] = '0; busy_a[i] = 0; ab_a[i] = 0; rst_a[i] = 0;
      end
      // directed scenarios
      put_task(2, 4'd3, 10'h010);                       // basic 3-edge task
      put_task(20, 4'd2, 10'h3FF);                      // address wrap
      put_task(30, 4'd1, 10'h055);                      // bank busy stall
      for (int i = 31; i <= 34; i++) busy_a[i] = 1;
      put_task(45, 4'd2, 10'h100);                      // overflow
      put_task(48, 4'd1, 10'h0AA);
      put_task(60, 4'd4, 10'h200);                      // abort
      ab_a[62] = 1;
      put_task(64, 4'd1, 10'h020);
      put_task(70, 4'd3, 10'h111);                      // reset mid-task
      rst_a[73] = 1;
      // random section
      for (int i = RAND0; i < RAND0 + RANDN; i++) begin
         tv_a[i]   = ($urandom_range(0, 3) == 0);
         tp_a[i]   = 14'($urandom);
         busy_a[i] = ($urandom_range(0, 2) == 0);
         ab_a[i]   = ($urandom_range(0, 59) == 0);
         rst_a[i]  = ($urandom_range(0, 399) == 0);
      end
      // 256 sixteen-edge tasks back to back
      rst_a[W0] = 1;
      for (int i = 0; i < 256; i++) put_task(W0 + 1 + WSPAN * i, 4'd0, 10'h3F8);

      build_expect();

      reset = 1'b1; abort = 1'b0;
      bus.task_in_valid = 1'b0; bus.task_in_packet = '0; bus.bank_busy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_pkt",   32'(bus.req_out_packet), 32'h0);
      chk("rst_valid", 32'(bus.req_out_valid),  32'h0);
      chk("rst_idle",  32'(bus.pe_idle),        32'h1);
      chk("rst_done",  32'(tasks_done),         32'h0);
      chk("rst_ovf",   32'(overflow),           32'h0);

      for (int c = 0; c < NCYC; c++) begin
         reset              = rst_a[c];
         abort              = ab_a[c];
         bus.task_in_valid  = tv_a[c];
         bus.task_in_packet = tp_a[c];
         bus.bank_busy      = busy_a[c];
         @(negedge clk);
         obs_v[c]    = bus.req_out_valid;
         obs_pkt[c]  = bus.req_out_packet;
         obs_idle[c] = bus.pe_idle;
         obs_done[c] = tasks_done;
         obs_ovf[c]  = overflow;
         if (obs_v[c] === 1'b1)
            $display("req edge=%0d pkt=%h type=%b idx=%0d addr=%h",
                     c, obs_pkt[c], obs_pkt[c][15:14], obs_pkt[c][13:10], obs_pkt[c][9:0]);
         chk($sformatf("valid@%0d", c), 32'(obs_v[c]),    32'(exp_v[c]));
         chk($sformatf("pkt@%0d", c),   32'(obs_pkt[c]),  32'(exp_pkt[c]));
         chk($sformatf("idle@%0d", c),  32'(obs_idle[c]), 32'(exp_idle[c]));
         chk($sformatf("done@%0d", c),  32'(obs_done[c]), 32'(exp_done[c]));
         chk($sformatf("ovf@%0d", c),   32'(obs_ovf[c]),  32'(exp_ovf[c]));
      end

      // fixed-value checks for the directed scenarios
      chk("t1_v0",    32'(obs_v[3]),    32'h1);
      chk("t1_p0",    32'(obs_pkt[3]),  32'h4010);
      chk("t1_gap",   32'(obs_v[4]),    32'h0);
      chk("t1_p1",    32'(obs_pkt[6]),  32'h4411);
      chk("t1_p2",    32'(obs_pkt[9]),  32'h8812);
      chk("t1_v2",    32'(obs_v[9]),    32'h1);
      chk("t1_busy",  32'(obs_idle[10]), 32'h0);
      chk("t1_idle",  32'(obs_idle[11]), 32'h1);
      chk("t1_done",  32'(obs_done[11]), 32'h1);
      chk("t2_p0",    32'(obs_pkt[21]), 32'h43FF);
      chk("t2_p1",    32'(obs_pkt[24]), 32'h8400);
      chk("t3_hold",  32'(obs_v[34]),   32'h0);
      chk("t3_v",     32'(obs_v[35]),   32'h1);
      chk("t3_once",  32'(obs_v[36]),   32'h0);
      chk("t3_p",     32'(obs_pkt[35]), 32'h8055);
      chk("t3_busy",  32'(obs_idle[36]), 32'h0);
      chk("t3_idle",  32'(obs_idle[37]), 32'h1);
      chk("t4_ovf0",  32'(obs_ovf[47]), 32'h0);
      chk("t4_ovf1",  32'(obs_ovf[48]), 32'h1);
      chk("t4_p1",    32'(obs_pkt[49]), 32'h8501);
      chk("t4_done",  32'(obs_done[51]), 32'h4);
      chk("t4_stick", 32'(obs_ovf[69]), 32'h1);
      chk("t5_p0",    32'(obs_pkt[61]), 32'h4200);
      chk("t5_idle",  32'(obs_idle[62]), 32'h1);
      chk("t5_nov",   32'(obs_v[64]),   32'h0);
      chk("t5_done",  32'(obs_done[62]), 32'h4);
      chk("t5_new",   32'(obs_pkt[65]), 32'h8020);
      chk("t5_done2", 32'(obs_done[67]), 32'h5);
      chk("rmid_busy", 32'(obs_idle[72]), 32'h0);
      chk("rmid_idle", 32'(obs_idle[73]), 32'h1);
      chk("rmid_pkt",  32'(obs_pkt[73]),  32'h0);
      chk("rmid_done", 32'(obs_done[73]), 32'h0);
      chk("rmid_ovf",  32'(obs_ovf[73]),  32'h0);
      chk("rmid_nov",  32'(obs_v[74]),    32'h0);
      tw = W0 + 1;
      chk("t6_first", 32'(obs_pkt[tw + 1]),  32'h43F8);
      chk("t6_lastv", 32'(obs_v[tw + 46]),   32'h1);
      chk("t6_last",  32'(obs_pkt[tw + 46]), 32'hBC07);
      chk("t6_idle",  32'(obs_idle[tw + 48]), 32'h1);
      chk("t6_255",   32'(obs_done[tw + WSPAN * 254 + 48]), 32'hFF);
      chk("t6_wrap",  32'(obs_done[tw + WSPAN * 255 + 48]), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
